nibble_tx_arbiter: RTL and testbench



---
 rtl/nibble_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_nibble_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_tx_arbiter.sv
// Round-robin arbiter that serializes one granted 4-bit nibble at a time, MSB first,
// with a forced idle gap between frames. Optional even-parity 5th bit: NIBBLE_ARB_PARITY_EN.
module nibble_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP   = 1,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] nib_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               d_ser,
  output logic               frame,
  output logic               last,
  output logic [ID_W-1:0]    src_id,
  output logic               busy
);

`ifdef NIBBLE_ARB_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam logic [2:0] LAST_BIT = 3'(NB - 1);
  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [NB-1:0]   sh_q, sh_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic            d_ser_q, d_ser_d;
  logic            frame_q, frame_d;
  logic            last_q, last_d;
  logic [ID_W-1:0] src_q, src_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [3:0]      nib_sel;
  logic [NB-1:0]   fb;
  logic            arb;

  // Search upward from the pointer; iterating the offsets downward leaves the nearest hit.
  always_comb begin : winner_search
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[ID_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
  end

  always_comb begin
    nib_sel = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == ID_W'(i)) nib_sel = nib_in[4*i +: 4];
    end
  end

`ifdef NIBBLE_ARB_PARITY_EN
  assign fb = {nib_sel, ^nib_sel};
`else
  assign fb = nib_sel;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    d_ser_d = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;
    src_d   = src_q;
    busy_d  = 1'b0;
    arb     = 1'b0;

    case (state_q)
      S_IDLE: arb = 1'b1;
      S_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          if (GAP == 0) begin
            arb = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 3'd1;
          d_ser_d = sh_q[NB-1];
          sh_d    = sh_q << 1;
          frame_d = 1'b1;
          last_d  = (cnt_q == LAST_BIT - 3'd1);
          busy_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          arb = 1'b1;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The register stage leading each frame: first bit and grant appear together.
    if (arb) begin
      if (win_found) begin
        state_d = S_SHIFT;
        cnt_d   = 3'd0;
        gnt_d   = N_REQ'(1) << win_idx;
        d_ser_d = fb[NB-1];
        sh_d    = fb << 1;
        frame_d = 1'b1;
        last_d  = 1'b0;
        src_d   = win_idx;
        busy_d  = 1'b1;
        ptr_d   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      d_ser_q <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      d_ser_q <= d_ser_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign d_ser  = d_ser_q;
  assign frame  = frame_q;
  assign last   = last_q;
  assign src_id = src_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_nibble_tx_arbiter.sv
// Bench for nibble_tx_arbiter: queue-based frame model checked every cycle, plus
// directed scenarios with literal expectations. Honours NIBBLE_ARB_PARITY_EN.
module tb_nibble_tx_arbiter;
  localparam int N_REQ = 4;
  localparam int GAP   = 1;
  localparam int ID_W  = 2;
`ifdef NIBBLE_ARB_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [4*N_REQ-1:0] nib_in = '0;
  logic [N_REQ-1:0]   gnt;
  logic               d_ser, frame, last, busy;
  logic [ID_W-1:0]    src_id;

  nibble_tx_arbiter #(.N_REQ(N_REQ), .GAP(GAP), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .nib_in(nib_in),
    .gnt(gnt), .d_ser(d_ser), .frame(frame), .last(last),
    .src_id(src_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Behavioural model: a frame is a list of future per-cycle records queued at arbitration.
  typedef struct packed {
    logic [N_REQ-1:0] g;
    logic             d;
    logic             f;
    logic             l;
    logic [ID_W-1:0]  s;
    logic             b;
  } rec_t;

  rec_t pend[$];
  rec_t exp_r = '0;
  int   m_ptr = 0;
  int   m_src = 0;

  function automatic rec_t mk(logic [N_REQ-1:0] g, logic d, logic f, logic l, int s, logic b);
    rec_t r;
    r.g = g; r.d = d; r.f = f; r.l = l; r.s = ID_W'(s); r.b = b;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        m_ptr = 0;
        m_src = 0;
        exp_r = '0;
      end else begin
        if (pend.size() == 0 && req != 0) begin
          int w;
          logic [3:0] nb;
          logic bitv;
          w = -1;
          for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_ptr + k) % N_REQ;
            if (w < 0 && ((req >> c) & 1) != 0) w = c;
          end
          nb = 4'(nib_in >> (4 * w));
          m_ptr = (w + 1) % N_REQ;
          m_src = w;
          for (int b = 0; b < NB; b++) begin
            bitv = (b < 4) ? ((nb >> (3 - b)) & 4'd1) != 0 : ^nb;
            pend.push_back(mk((b == 0) ? N_REQ'(1) << w : '0, bitv, 1'b1, b == NB - 1, w, 1'b1));
          end
          for (int g = 0; g < GAP; g++) pend.push_back(mk('0, 1'b0, 1'b0, 1'b0, w, 1'b1));
        end
        if (pend.size() > 0) exp_r = pend.pop_front();
        else exp_r = mk('0, 1'b0, 1'b0, 1'b0, m_src, 1'b0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("cycle", 32'({gnt, d_ser, frame, last, src_id, busy}), 32'(exp_r));
    end
  end

  // Waits (bounded) for a grant, then captures the whole frame off the line.
  task automatic frame_collect(input logic [N_REQ-1:0] req_after, output int idx,
                               output logic [NB-1:0] bits, output int waited);
    logic [NB-1:0] lasts;
    logic          fr_ok;
    logic [ID_W-1:0] src0;
    idx = -1;
    bits = '0;
    lasts = '0;
    fr_ok = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (gnt == 0 && waited < 20);
    if (gnt == 0) begin
      check("gnt_timeout", 32'(0), 32'(1));
      return;
    end
    for (int k = 0; k < N_REQ; k++) if (gnt == N_REQ'(1) << k) idx = k;
    check("gnt_onehot", 32'(idx >= 0), 32'(1));
    src0 = src_id;
    req = req_after;
    for (int b = 0; b < NB; b++) begin
      if (b > 0) @(negedge clk);
      bits[NB-1-b] = d_ser;
      lasts[NB-1-b] = last;
      fr_ok = fr_ok & frame;
    end
    check("frame_high", 32'(fr_ok), 32'(1));
    check("last_pos", 32'(lasts), 32'(1));
    check("src_id", 32'(src0), 32'(idx));
`ifdef NIBBLE_ARB_PARITY_EN
    check("parity_bit", 32'(bits[0]), 32'(^bits[NB-1:1]));
`endif
  endtask

  int idx, waited;
  logic [NB-1:0] bits;
  int   ex_i[5] = '{0, 1, 2, 3, 0};
  logic [3:0] ex_n[5] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hA};
  int   sk_i[4] = '{2, 3, 0, 3};

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    // Reset held: requests toggle, outputs must stay cleared.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_outs", 32'({gnt, d_ser, frame, last, src_id, busy}), 32'(0));
      req = (c % 2 == 0) ? 4'b1111 : 4'b0000;
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full contention
    nib_in = 16'h3C5A;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      frame_collect((f == 4) ? 4'b0000 : 4'b1111, idx, bits, waited);
      check("rr_order", 32'(idx), 32'(ex_i[f]));
      check("rr_nibble", 32'(bits[NB-1 -: 4]), 32'(ex_n[f]));
      check("rr_period", 32'(waited), 32'((f == 0) ? 1 : 1 + GAP));
    end

    // Round-robin skip: requester 1 must never win
    req = 4'b0100;
    for (int f = 0; f < 4; f++) begin
      frame_collect((f == 3) ? 4'b0000 : 4'b1001, idx, bits, waited);
      check("skip_order", 32'(idx), 32'(sk_i[f]));
    end
    repeat (3) @(negedge clk);

    // Single source, gap and return to idle
    nib_in = 16'h000B;
    req = 4'b0001;
    frame_collect(4'b0000, idx, bits, waited);
    check("single_idx", 32'(idx), 32'(0));
    check("single_latency", 32'(waited), 32'(1));
`ifdef NIBBLE_ARB_PARITY_EN
    check("single_bits", 32'(bits), 32'(5'b10111));
`else
    check("single_bits", 32'(bits), 32'(4'b1011));
`endif
    @(negedge clk);
    check("gap_cycle", 32'({frame, busy, d_ser}), 32'(3'b010));
    @(negedge clk);
    check("idle_after", 32'({frame, busy}), 32'(0));

    // Asynchronous reset in the middle of a frame
    nib_in = 16'hFFFF;
    req = 4'b1111;
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'(4'b0010));
    req = 4'b0000;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({gnt, d_ser, frame, last, src_id, busy}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1100;
    frame_collect(4'b0000, idx, bits, waited);
    check("post_rst_idx", 32'(idx), 32'(2));
    check("post_rst_lat", 32'(waited), 32'(1));
    repeat (3) @(negedge clk);

`ifdef NIBBLE_ARB_PARITY_EN
    nib_in = 16'h0007;
    req = 4'b0001;
    frame_collect(4'b0000, idx, bits, waited);
    check("par_0111", 32'(bits), 32'(5'b01111));
    repeat (3) @(negedge clk);
    nib_in = 16'h0005;
    req = 4'b0001;
    frame_collect(4'b0000, idx, bits, waited);
    check("par_0101", 32'(bits), 32'(5'b01010));
    repeat (3) @(negedge clk);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      nib_in = 16'($urandom);
      if (c == 250) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    req = '0;
    repeat (12) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
